spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI slave endpoint: FPGA responds to an external SPI master (the DUT MCU) on logical pins.
//  Oversamples sclk/cs_n/mosi on clk, shifts symbols both ways, counts starts/stops/transfers.
//  Checksums received symbols; transmits a decrementing sequence from a programmable seed.
//  Wrapped by an APB2 register block.
// PARAMETERS
//  DATA_W   32  max symbol width in bits (sym_size range 1..DATA_W)
//  CNT_W    16  width of starts/stops/transfers counters
// PORTS
//  clk             in   1       system clock; must be >= 8x sclk frequency
//  rst_n           in   1       asynchronous, active-low reset
//  sclk_in         in   1       SPI clock from master (asynchronous to clk)
//  cs_n_in         in   1       chip select from master, active low
//  mosi_in         in   1       data from master
//  miso_out        out  1       data to master
//  miso_drive      out  1       output enable for miso pin; 1 only while selected
//  cpol            in   1       clock idle level
//  cpha            in   1       0: sample leading edge; 1: sample trailing edge
//  msb_first       in   1       bit order for both directions
//  sym_size        in   6       bits per symbol; 0 or >DATA_W treated as DATA_W
//  tx_seed         in   DATA_W  first symbol sent to master
//  clear           in   1       sync pulse: zero counters, checksum, rx_data
//  rx_data         out  DATA_W  last complete symbol received, right-aligned
//  rx_valid        out  1       one-cycle pulse when rx_data updates
//  starts          out  CNT_W   cs_n falling edges seen
//  stops           out  CNT_W   cs_n rising edges seen
//  transfers       out  CNT_W   complete symbols exchanged
//  rx_checksum     out  32      mod-2^32 sum of all complete received symbols
//  busy            out  1       1 while in ACTIVE state
// BEHAVIOUR
//  Reset: all outputs 0 (miso_out=0, miso_drive=0); state IDLE; tx shift reg = 0.
//  Inputs pass 2-FF synchronizers; edges detected on 3rd stage -> pin-to-action 3 clk.
//  Leading edge = sclk leaving cpol level; trailing = sclk returning to cpol level.
//  Sample edge = leading if cpha=0 else trailing; shift edge = the other one.
//  FSM IDLE: on cs_n fall -> ACTIVE; starts++; latch cpol/cpha/msb_first/sym_size;
//   load tx_seed into tx reg; bit_cnt=0; miso_drive=1; if cpha=0 first bit on miso now.
//  ACTIVE sample edge: shift mosi into rx reg (msb_first: shift left in at LSB;
//   else shift right in at bit sym_size-1); bit_cnt++.
//  ACTIVE shift edge: present next tx bit on miso_out; cpha=1 presents bit 0 of symbol on
//   first leading edge. miso_out holds between edges.
//  Symbol complete when bit_cnt reaches sym_size on a sample edge: next clk rx_data<=rx reg,
//   rx_valid=1, transfers++, rx_checksum+=rx reg (zero-extended/truncated to 32), bit_cnt=0;
//   tx reg <= previous tx symbol - 1 (mod 2^sym_size), first bit per cpha rule.
//  cs_n rise in ACTIVE -> IDLE; stops++; miso_drive=0 same cycle; partial symbol discarded
//   (no rx_valid, no count, no checksum); next select restarts from tx_seed.
//  sclk edges while cs_n high ignored. Config changes during ACTIVE ignored until next select.
//  Counters and checksum wrap silently. clear has priority over same-cycle increments.
//  cs_n fall and rise within sync window both detected in order; starts/stops stay balanced.
//  rst_n low mid-transfer: immediate return to reset values; master sees miso undriven.
// TESTING
//  mode0 msb, sym 8, seed 0xAA, master sends 0x55,0x56,0x57 -> rx 0x55..0x57, miso 0xAA,0xA9,0xA8,
//   transfers=3, starts=stops=1, checksum=0x102.
//  mode3 lsb-first, sym 16, seed 0x1234, 2 symbols 0xBEEF,0x0001 -> rx matches, miso 0x1234,0x1233.
//  cs_n raised after 5 of 8 bits -> no rx_valid, transfers unchanged, stops++, miso_drive=0.
//  sym_size 0 with DATA_W=32, one symbol 0xDEADBEEF -> rx_data 0xDEADBEEF, checksum 0xDEADBEEF.
//  300 symbols seed 0x00 sym 8 -> miso wraps 0x00,0xFF,..; transfers=300; checksum per model.
//  rst_n asserted mid-symbol, then clear pulse; -> all outputs 0; next select starts fresh.

Source files
------------

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI slave endpoint: oversampled pins, two-way symbol shifter,
// select/deselect/transfer counters and a checksum of received symbols.
module spi_slave_responder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk_in,
    input  logic              i_cs_n_in,
    input  logic              i_mosi_in,
    output logic              o_miso_out,
    output logic              o_miso_drive,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_msb_first,
    input  logic [5:0]        i_sym_size,
    input  logic [DATA_W-1:0] i_tx_seed,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic [CNT_W-1:0]  o_starts,
    output logic [CNT_W-1:0]  o_stops,
    output logic [CNT_W-1:0]  o_transfers,
    output logic [31:0]       o_rx_checksum,
    output logic              o_busy
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [2:0]          r_sclk_sync;
    logic [2:0]          r_cs_sync;
    logic [1:0]          r_mosi_sync;

    logic                r_cpol;
    logic                r_cpha;
    logic                r_msb;
    logic [5:0]          r_size;
    logic [5:0]          r_bit_cnt;
    logic                r_done;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_tx_sym;
    logic                r_miso;

    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic [CNT_W-1:0]    r_starts;
    logic [CNT_W-1:0]    r_stops;
    logic [CNT_W-1:0]    r_transfers;
    logic [31:0]         r_checksum;

    logic                w_cs_fall;
    logic                w_cs_rise;
    logic                w_select;
    logic                w_deselect;
    logic                w_act;
    logic                w_sclk_edge;
    logic                w_lead;
    logic                w_trail;
    logic                w_sample;
    logic                w_shift;
    logic [5:0]          w_size_in;
    logic [DATA_W-1:0]   w_seed_masked;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_rx_msb;
    logic [DATA_W-1:0]   w_rx_lsb;
    logic [DATA_W-1:0]   w_rx_sym;
    logic [DATA_W-1:0]   w_tx_dec;

    function automatic logic [DATA_W-1:0] f_mask(input logic [5:0] size);
        return {DATA_W{1'b1}} >> (6'(DATA_W) - size);
    endfunction

    // Bit idx in transmit order of a size-bit symbol.
    function automatic logic f_tx_bit(input logic [DATA_W-1:0] sym, input logic [5:0] size,
                                      input logic msb, input logic [5:0] idx);
        logic [DATA_W-1:0] v;
        v = msb ? (sym >> (size - 6'd1 - idx)) : (sym >> idx);
        return v[0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk_in};
            r_cs_sync   <= {r_cs_sync[1:0], i_cs_n_in};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi_in};
        end
    end

    assign w_cs_fall   = r_cs_sync[2] & ~r_cs_sync[1];
    assign w_cs_rise   = ~r_cs_sync[2] & r_cs_sync[1];
    assign w_select    = (r_state == S_IDLE) && w_cs_fall;
    assign w_deselect  = (r_state == S_ACTIVE) && w_cs_rise;
    assign w_act       = (r_state == S_ACTIVE) && !r_cs_sync[1];
    assign w_sclk_edge = r_sclk_sync[2] ^ r_sclk_sync[1];
    assign w_lead      = w_sclk_edge && (r_sclk_sync[2] == r_cpol);
    assign w_trail     = w_sclk_edge && (r_sclk_sync[1] == r_cpol);
    assign w_sample    = w_act && (r_cpha ? w_trail : w_lead);
    assign w_shift     = w_act && (r_cpha ? w_lead : w_trail);

    assign w_size_in     = ((i_sym_size == 6'd0) || (i_sym_size > 6'(DATA_W))) ? 6'(DATA_W) : i_sym_size;
    assign w_seed_masked = i_tx_seed & f_mask(w_size_in);
    assign w_mask        = f_mask(r_size);
    assign w_rx_msb      = {r_rx[DATA_W-2:0], r_mosi_sync[1]};
    assign w_rx_lsb      = (r_rx >> 1) | ({{(DATA_W-1){1'b0}}, r_mosi_sync[1]} << (r_size - 6'd1));
    assign w_rx_sym      = r_rx & w_mask;
    assign w_tx_dec      = (r_tx_sym - {{(DATA_W-1){1'b0}}, 1'b1}) & w_mask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_cs_rise) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Shift engine. The shift edge always presents the bit indexed by the number of samples
    // already taken, so the edge right after a symbol completes re-presents bit 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_msb     <= 1'b0;
            r_size    <= 6'(DATA_W);
            r_bit_cnt <= 6'd0;
            r_done    <= 1'b0;
            r_rx      <= '0;
            r_tx_sym  <= '0;
            r_miso    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_select) begin
                r_cpol    <= i_cpol;
                r_cpha    <= i_cpha;
                r_msb     <= i_msb_first;
                r_size    <= w_size_in;
                r_bit_cnt <= 6'd0;
                r_rx      <= '0;
                r_tx_sym  <= w_seed_masked;
                r_miso    <= i_cpha ? 1'b0 : f_tx_bit(w_seed_masked, w_size_in, i_msb_first, 6'd0);
            end else if (w_deselect) begin
                r_bit_cnt <= 6'd0;
                r_miso    <= 1'b0;
            end else if (r_done) begin
                r_bit_cnt <= 6'd0;
                r_rx      <= '0;
                r_tx_sym  <= w_tx_dec;
                if (!r_cpha) begin
                    r_miso <= f_tx_bit(w_tx_dec, r_size, r_msb, 6'd0);
                end
            end else begin
                if (w_sample) begin
                    r_rx      <= r_msb ? w_rx_msb : w_rx_lsb;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    r_done    <= ((r_bit_cnt + 6'd1) == r_size);
                end
                if (w_shift) begin
                    r_miso <= f_tx_bit(r_tx_sym, r_size, r_msb, r_bit_cnt);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_starts    <= '0;
            r_stops     <= '0;
            r_transfers <= '0;
            r_checksum  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (i_clear) begin
                r_rx_data   <= '0;
                r_starts    <= '0;
                r_stops     <= '0;
                r_transfers <= '0;
                r_checksum  <= '0;
            end else begin
                if (w_select) begin
                    r_starts <= r_starts + 1'b1;
                end
                if (w_deselect) begin
                    r_stops <= r_stops + 1'b1;
                end
                if (r_done) begin
                    r_rx_data   <= w_rx_sym;
                    r_rx_valid  <= 1'b1;
                    r_transfers <= r_transfers + 1'b1;
                    r_checksum  <= r_checksum + 32'(w_rx_sym);
                end
            end
        end
    end

    assign o_miso_out    = r_miso;
    assign o_miso_drive  = (r_state == S_ACTIVE);
    assign o_busy        = (r_state == S_ACTIVE);
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_starts      = r_starts;
    assign o_stops       = r_stops;
    assign o_transfers   = r_transfers;
    assign o_rx_checksum = r_checksum;

endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - bench for spi_slave_responder: bit-banged SPI master,
// expected symbols queued at stimulus time and compared by a separate monitor.
module tb_spi_slave_responder;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int HALF   = 6;

    logic              clk;
    logic              rst_n;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_drive;
    logic              cpol;
    logic              cpha;
    logic              msb_first;
    logic [5:0]        sym_size;
    logic [DATA_W-1:0] tx_seed;
    logic              clear;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [CNT_W-1:0]  starts;
    logic [CNT_W-1:0]  stops;
    logic [CNT_W-1:0]  transfers;
    logic [31:0]       rx_checksum;
    logic              busy;

    int total;
    int bad;

    logic [31:0] mosi_q[$];
    logic [31:0] exp_rx[$];
    logic [31:0] exp_miso[$];
    logic [31:0] cap_miso[$];

    logic [31:0] mon_e;
    logic [31:0] mon_c;
    logic [31:0] model_sum;

    spi_slave_responder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_sclk_in     (sclk),
        .i_cs_n_in     (cs_n),
        .i_mosi_in     (mosi),
        .o_miso_out    (miso),
        .o_miso_drive  (miso_drive),
        .i_cpol        (cpol),
        .i_cpha        (cpha),
        .i_msb_first   (msb_first),
        .i_sym_size    (sym_size),
        .i_tx_seed     (tx_seed),
        .i_clear       (clear),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .o_starts      (starts),
        .o_stops       (stops),
        .o_transfers   (transfers),
        .o_rx_checksum (rx_checksum),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic pol, input logic pha, input logic msb, input logic [5:0] size,
                           input logic [31:0] seed);
        cpol      = pol;
        cpha      = pha;
        msb_first = msb;
        sym_size  = size;
        tx_seed   = seed;
        sclk      = pol;
        wait_clk(HALF);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        wait_clk(1);
        clear = 1'b0;
        wait_clk(1);
    endtask

    // Sends every symbol in mosi_q as one select; stop_bits > 0 aborts after that many bits.
    task automatic spi_frame(input logic pol, input logic pha, input logic msb, input int n,
                             input int stop_bits);
        int          done_bits;
        int          pos;
        logic        abort;
        logic [31:0] sym;
        logic [31:0] cap;
        done_bits = 0;
        abort     = 1'b0;
        sclk      = pol;
        wait_clk(HALF);
        cs_n = 1'b0;
        while (mosi_q.size() > 0 && !abort) begin
            sym = mosi_q.pop_front();
            cap = '0;
            for (int b = 0; b < n; b++) begin
                pos = msb ? (n - 1 - b) : b;
                if (!pha) begin
                    mosi = sym[pos];
                    wait_clk(HALF);
                    sclk = ~pol;
                    cap[pos] = miso;
                    wait_clk(HALF);
                    sclk = pol;
                end else begin
                    wait_clk(HALF);
                    sclk = ~pol;
                    mosi = sym[pos];
                    wait_clk(HALF);
                    sclk = pol;
                    cap[pos] = miso;
                end
                done_bits++;
                if (done_bits == stop_bits) begin
                    abort = 1'b1;
                    break;
                end
            end
            if (!abort) cap_miso.push_back(cap);
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(3 * HALF);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (exp_rx.size() == 0) begin
                    check("rx_valid_unexpected", 64'(rx_valid), 64'd0);
                end else begin
                    mon_e = exp_rx.pop_front();
                    check("rx_data", 64'(rx_data), 64'(mon_e));
                end
            end
            if (cap_miso.size() > 0) begin
                mon_c = cap_miso.pop_front();
                if (exp_miso.size() == 0) begin
                    check("miso_unexpected", 64'(mon_c), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = exp_miso.pop_front();
                    check("miso_sym", 64'(mon_c), 64'(mon_e));
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; clear = 1'b0;
        cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; sym_size = 6'd8; tx_seed = '0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        check("rst_miso",       64'(miso),        64'd0);
        check("rst_miso_drive", 64'(miso_drive),  64'd0);
        check("rst_busy",       64'(busy),        64'd0);
        check("rst_rx_data",    64'(rx_data),     64'd0);
        check("rst_starts",     64'(starts),      64'd0);
        check("rst_checksum",   64'(rx_checksum), 64'd0);

        // mode 0, MSB first, 8-bit symbols
        set_cfg(1'b0, 1'b0, 1'b1, 6'd8, 32'hAA);
        mosi_q = '{32'h55, 32'h56, 32'h57};
        exp_rx = '{32'h55, 32'h56, 32'h57};
        exp_miso = '{32'hAA, 32'hA9, 32'hA8};
        spi_frame(1'b0, 1'b0, 1'b1, 8, 0);
        check("m0_transfers", 64'(transfers),   64'd3);
        check("m0_starts",    64'(starts),      64'd1);
        check("m0_stops",     64'(stops),       64'd1);
        check("m0_checksum",  64'(rx_checksum), 64'h102);
        check("m0_rx_data",   64'(rx_data),     64'h57);
        check("m0_drive_off", 64'(miso_drive),  64'd0);

        pulse_clear();
        check("clr_transfers", 64'(transfers),   64'd0);
        check("clr_checksum",  64'(rx_checksum), 64'd0);
        check("clr_rx_data",   64'(rx_data),     64'd0);

        // mode 3, LSB first, 16-bit symbols
        set_cfg(1'b1, 1'b1, 1'b0, 6'd16, 32'h1234);
        mosi_q = '{32'hBEEF, 32'h0001};
        exp_rx = '{32'hBEEF, 32'h0001};
        exp_miso = '{32'h1234, 32'h1233};
        spi_frame(1'b1, 1'b1, 1'b0, 16, 0);
        check("m3_transfers", 64'(transfers),   64'd2);
        check("m3_checksum",  64'(rx_checksum), 64'hBEF0);
        check("m3_stops",     64'(stops),       64'd1);

        // deselect after 5 of 8 bits
        pulse_clear();
        set_cfg(1'b0, 1'b0, 1'b1, 6'd8, 32'h5A);
        mosi_q = '{32'hF0};
        spi_frame(1'b0, 1'b0, 1'b1, 8, 5);
        check("part_transfers", 64'(transfers),   64'd0);
        check("part_starts",    64'(starts),      64'd1);
        check("part_stops",     64'(stops),       64'd1);
        check("part_drive",     64'(miso_drive),  64'd0);
        check("part_checksum",  64'(rx_checksum), 64'd0);

        // sym_size 0 means full 32-bit symbols
        pulse_clear();
        set_cfg(1'b0, 1'b0, 1'b1, 6'd0, 32'hCAFEF00D);
        mosi_q = '{32'hDEADBEEF};
        exp_rx = '{32'hDEADBEEF};
        exp_miso = '{32'hCAFEF00D};
        spi_frame(1'b0, 1'b0, 1'b1, 32, 0);
        check("s0_checksum",  64'(rx_checksum), 64'hDEADBEEF);
        check("s0_rx_data",   64'(rx_data),     64'hDEADBEEF);
        check("s0_transfers", 64'(transfers),   64'd1);

        // 300 symbols in mode 1, seed 0: tx sequence wraps 0x00, 0xFF, 0xFE, ...
        pulse_clear();
        set_cfg(1'b0, 1'b1, 1'b1, 6'd8, 32'h00);
        model_sum = '0;
        for (int i = 0; i < 300; i++) begin
            mon_e = 32'((i * 37 + 11) & 255);
            mosi_q.push_back(mon_e);
            exp_rx.push_back(mon_e);
            exp_miso.push_back(32'((256 - (i % 256)) % 256));
            model_sum = model_sum + mon_e;
        end
        spi_frame(1'b0, 1'b1, 1'b1, 8, 0);
        check("long_transfers", 64'(transfers),   64'd300);
        check("long_checksum",  64'(rx_checksum), 64'(model_sum));
        check("long_starts",    64'(starts),      64'd1);

        // reset in the middle of a symbol
        pulse_clear();
        set_cfg(1'b0, 1'b0, 1'b1, 6'd8, 32'h3C);
        cs_n = 1'b0;
        wait_clk(HALF);
        check("mid_busy",   64'(busy),       64'd1);
        check("mid_drive",  64'(miso_drive), 64'd1);
        check("mid_starts", 64'(starts),     64'd1);
        sclk = 1'b1; wait_clk(HALF);
        sclk = 1'b0; wait_clk(HALF);
        sclk = 1'b1; wait_clk(2);
        rst_n = 1'b0;
        wait_clk(2);
        check("rstm_miso",     64'(miso),        64'd0);
        check("rstm_drive",    64'(miso_drive),  64'd0);
        check("rstm_busy",     64'(busy),        64'd0);
        check("rstm_starts",   64'(starts),      64'd0);
        check("rstm_stops",    64'(stops),       64'd0);
        check("rstm_rx_valid", 64'(rx_valid),    64'd0);
        sclk = 1'b0;
        cs_n = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(HALF);
        pulse_clear();
        check("post_starts", 64'(starts), 64'd0);
        mosi_q = '{32'h81};
        exp_rx = '{32'h81};
        exp_miso = '{32'h3C};
        spi_frame(1'b0, 1'b0, 1'b1, 8, 0);
        check("fresh_starts",    64'(starts),      64'd1);
        check("fresh_stops",     64'(stops),       64'd1);
        check("fresh_transfers", 64'(transfers),   64'd1);
        check("fresh_checksum",  64'(rx_checksum), 64'h81);

        wait_clk(4);
        check("rx_queue_drained",   64'(exp_rx.size()),   64'd0);
        check("miso_queue_drained", 64'(exp_miso.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
